// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive controller: FSM state encoding,
// the legal oversampling ratios and the frame bit positions.
package uart_rx_pkg;

  // State encoding of the frame-sequencing FSM.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_e;

  // Oversampling ratios the sampler and counters are built for.
  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // Frame bit positions as seen on bit_cnt (default 8-bit payload, no parity).
  localparam int DATA_WIDTH_DEF = 8;
  localparam int START_IDX      = 0;
  localparam int STOP_IDX       = DATA_WIDTH_DEF + 1;

  // Stop bit position for a given payload width; a parity bit pushes it out by one.
  function automatic int stop_idx(input int data_width, input logic par_en);
    return data_width + 1 + (par_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the receive controller and its neighbours
// (line input, sampler, deserializer, status consumers).
// Optional feature macro: UART_RX_ERR_CNT_EN adds err_cnt / err_cnt_clr.
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);

  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  sampled_bit;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  dat_samp_en;
  logic                  deser_en;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0]            err_cnt;
  logic                  err_cnt_clr;

  // Controller side.
  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit, P_DATA, err_cnt_clr,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en, data_valid, par_err, stp_err, err_cnt
  );

  // Environment side: line, sampler, deserializer and status consumer.
  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit, P_DATA, err_cnt_clr,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en, data_valid, par_err, stp_err, err_cnt
  );
`else
  // Controller side.
  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit, P_DATA,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en, data_valid, par_err, stp_err
  );

  // Environment side: line, sampler, deserializer and status consumer.
  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit, P_DATA,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en, data_valid, par_err, stp_err
  );
`endif

endinterface

// File: rtl/uart_rx_ctrl_edge_bit_cnt.sv
// Oversample edge counter and frame bit counter. While enabled, edge_cnt
// runs 0..prescale-1 and bit_cnt advances on every wrap; when disabled
// both counters are held at zero.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [PRESCALE_W-1:0] edge_cnt_o,
  output logic [BIT_CNT_W-1:0]  bit_cnt_o,
  output logic                  bit_end_o
);

  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;

  assign bit_end_o  = (edge_q == (prescale_i - 1'b1));
  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

  // Next count: clear when disabled, wrap edge_cnt and bump bit_cnt at bit end.
  always_comb begin
    edge_d = '0;
    bit_d  = '0;
    if (en_i) begin
      if (bit_end_o) begin
        edge_d = '0;
        bit_d  = bit_q + 1'b1;
      end else begin
        edge_d = edge_q + 1'b1;
        bit_d  = bit_q;
      end
    end
  end

  // Counter registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer. Detects the start bit, drives the sampler
// and deserializer enables, checks start/parity/stop bits and pulses
// data_valid for each good frame.
// Optional feature macro: UART_RX_ERR_CNT_EN adds a saturating 8-bit count
// of bad frames (err_cnt) with a synchronous clear (err_cnt_clr).
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  uart_rx_ctrl_if.slave    bus
);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  data_valid_q, data_valid_d;

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  bit_end;
  logic                  cnt_en;

  // Counters run only while the FSM stays inside a frame; entering or
  // leaving IDLE restarts them at zero so every frame begins at edge 0.
  assign cnt_en = (state_q != IDLE) && (state_d != IDLE);

  uart_rx_edge_bit_cnt #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_cnt (
    .CLK        (CLK),
    .RST        (RST),
    .en_i       (cnt_en),
    .prescale_i (prescale_q),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt),
    .bit_end_o  (bit_end)
  );

  // Next-state logic, config capture and bit checks.
  always_comb begin
    state_d      = state_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;
    data_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.RX_IN) begin
          state_d    = START;
          prescale_d = bus.Prescale;
          par_en_d   = bus.PAR_EN;
          par_typ_d  = bus.PAR_TYP;
          par_err_d  = 1'b0;
          stp_err_d  = 1'b0;
        end
      end
      START: begin
        // A start bit that reads high at its end was a line glitch.
        if (bit_end) begin
          state_d = bus.sampled_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end && (bit_cnt == BIT_CNT_W'(DATA_WIDTH))) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_err_d = bus.sampled_bit != ((^bus.P_DATA) ^ par_typ_q);
          state_d   = STOP;
        end
      end
      STOP: begin
        // A low line here is a framing error, never a new start bit.
        if (bit_end) begin
          stp_err_d    = ~bus.sampled_bit;
          data_valid_d = bus.sampled_bit & ~par_err_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and status registers, cleared asynchronously from any state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Frame configuration latch; only meaningful outside IDLE, so no reset.
  always_ff @(posedge CLK) begin
    prescale_q <= prescale_d;
    par_en_q   <= par_en_d;
    par_typ_q  <= par_typ_d;
  end

  assign bus.edge_cnt    = edge_cnt;
  assign bus.bit_cnt     = bit_cnt;
  assign bus.dat_samp_en = (state_q != IDLE);
  assign bus.deser_en    = (state_q == DATA);
  assign bus.data_valid  = data_valid_q;
  assign bus.par_err     = par_err_q;
  assign bus.stp_err     = stp_err_q;

`ifdef UART_RX_ERR_CNT_EN
  logic       frame_bad;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign frame_bad = (state_q == STOP) && bit_end && (~bus.sampled_bit | par_err_q);

  // Saturating bad-frame count; a clear wins over a same-cycle increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (frame_bad && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Bad-frame counter register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl. Drives serial frames on RX_IN,
// models the sampler (majority result updated mid-bit) and an LSB-first
// deserializer, and scores data_valid pulses against a queue of expected
// bytes. Optional feature macro: UART_RX_ERR_CNT_EN enables err_cnt checks.
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  int checks       = 0;
  int errors       = 0;
  int cyc          = 0;
  int deser_cycles = 0;
  int dv_count     = 0;

  logic [7:0] exp_q[$];
  int         dv_t[$];
  logic [7:0] p_data_q = 8'h00;

  always #5 CLK = ~CLK;

  uart_rx_ctrl_if #(.DATA_WIDTH(8), .PRESCALE_W(6), .BIT_CNT_W(4)) bus ();

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6), .BIT_CNT_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  assign bus.P_DATA = p_data_q;

  // Deserializer model: shift the sampler result in LSB-first at each data bit end.
  always @(posedge CLK) begin
    if (bus.deser_en && (bus.edge_cnt == (bus.Prescale - 6'd1))) begin
      p_data_q <= {bus.sampled_bit, p_data_q[7:1]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      bus.RX_IN = 1'b1;
    end
  endtask

  // Drives one frame (start, 8 data bits LSB first, optional parity, stop);
  // stops early after max_cycles line cycles.
  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                            input logic stop_bit, input int p, input int max_cycles);
    logic [10:0] bits;
    int          nb;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (par_en) begin
      bits[9]  = par_bit;
      bits[10] = stop_bit;
      nb       = 11;
    end else begin
      bits[9]  = stop_bit;
      nb       = 10;
    end
    bus.Prescale = 6'(p);
    bus.PAR_EN   = par_en;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < p; c++) begin
        if (b * p + c >= max_cycles) return;
        @(negedge CLK);
        bus.RX_IN = bits[b];
        if (c == p / 2) bus.sampled_bit = bits[b];
      end
    end
  endtask

  // Output monitor: counts deser_en cycles and scores data_valid pulses.
  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (bus.deser_en === 1'b1) deser_cycles++;
      if (bus.data_valid === 1'b1) begin
        dv_count++;
        dv_t.push_back(cyc);
        chk("dv_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("p_data", 32'(bus.P_DATA), 32'(exp_q.pop_front()));
      end
    end
  end

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: observed time %0t, required finish before 1000000", $time);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int dv0;
    int d0;

    bus.RX_IN       = 1'b1;
    bus.Prescale    = 6'(PRESCALE_8);
    bus.PAR_EN      = 1'b0;
    bus.PAR_TYP     = 1'b0;
    bus.sampled_bit = 1'b1;
`ifdef UART_RX_ERR_CNT_EN
    bus.err_cnt_clr = 1'b0;
`endif

    // Reset state.
    repeat (3) @(negedge CLK);
    chk("rst_edge_cnt",    32'(bus.edge_cnt),    32'd0);
    chk("rst_bit_cnt",     32'(bus.bit_cnt),     32'd0);
    chk("rst_dat_samp_en", 32'(bus.dat_samp_en), 32'd0);
    chk("rst_deser_en",    32'(bus.deser_en),    32'd0);
    chk("rst_data_valid",  32'(bus.data_valid),  32'd0);
    chk("rst_par_err",     32'(bus.par_err),     32'd0);
    chk("rst_stp_err",     32'(bus.stp_err),     32'd0);
`ifdef UART_RX_ERR_CNT_EN
    chk("rst_err_cnt",     32'(bus.err_cnt),     32'd0);
`endif
    RST = 1'b1;
    idle(4);

    // 1: Prescale 8, even parity, 0xA5 with correct parity bit 0.
    bus.PAR_TYP = 1'b0;
    d0 = deser_cycles; dv0 = dv_count;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, PRESCALE_8, 1000);
    idle(PRESCALE_8 + 4);
    chk("t1_deser_cycles", 32'(deser_cycles - d0), 32'd64);
    chk("t1_dv_pulses",    32'(dv_count - dv0),    32'd1);
    chk("t1_queue_empty",  32'(exp_q.size()),      32'd0);
    chk("t1_par_err",      32'(bus.par_err),       32'd0);
    chk("t1_stp_err",      32'(bus.stp_err),       32'd0);

    // 2: same frame, wrong parity bit; flag must persist while idle.
    dv0 = dv_count;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, PRESCALE_8, 1000);
    idle(PRESCALE_8 + 4);
    chk("t2_par_err",   32'(bus.par_err),     32'd1);
    chk("t2_stp_err",   32'(bus.stp_err),     32'd0);
    chk("t2_dv_pulses", 32'(dv_count - dv0),  32'd0);
    idle(20);
    chk("t2_par_err_hold", 32'(bus.par_err),  32'd1);

    // 3: Prescale 16, no parity, 0x3C with a low stop bit.
    dv0 = dv_count;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, PRESCALE_16, 1000);
    idle(PRESCALE_16 + 4);
    chk("t3_stp_err",   32'(bus.stp_err),     32'd1);
    chk("t3_par_err",   32'(bus.par_err),     32'd0);
    chk("t3_dv_pulses", 32'(dv_count - dv0),  32'd0);

    // 4: 3-cycle low glitch at Prescale 8; sampler sees the line high mid-bit.
    bus.Prescale = 6'(PRESCALE_8);
    bus.PAR_EN   = 1'b0;
    d0 = deser_cycles; dv0 = dv_count;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      bus.RX_IN = 1'b0;
    end
    @(negedge CLK);
    bus.RX_IN = 1'b1;
    @(negedge CLK);
    bus.sampled_bit = 1'b1;
    #1;
    chk("t4_samp_en_in_start", 32'(bus.dat_samp_en), 32'd1);
    chk("t4_bit_cnt_start",    32'(bus.bit_cnt),     32'(START_IDX));
    idle(12);
    chk("t4_back_to_idle", 32'(bus.dat_samp_en),       32'd0);
    chk("t4_deser_never",  32'(deser_cycles - d0),     32'd0);
    chk("t4_par_err",      32'(bus.par_err),           32'd0);
    chk("t4_stp_err",      32'(bus.stp_err),           32'd0);
    chk("t4_dv_pulses",    32'(dv_count - dv0),        32'd0);
    chk("t4_edge_cnt",     32'(bus.edge_cnt),          32'd0);
    chk("t4_bit_cnt",      32'(bus.bit_cnt),           32'd0);

    // 5: Prescale 32, back-to-back 0x3C and 0xC3 with no idle gap.
    dv0 = dv_count;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, PRESCALE_32, 1000);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, PRESCALE_32, 1000);
    idle(PRESCALE_32 + 4);
    chk("t5_dv_pulses",   32'(dv_count - dv0), 32'd2);
    chk("t5_queue_empty", 32'(exp_q.size()),   32'd0);
    // Each frame spends one detect cycle in IDLE before its 10 bit times.
    if (dv_t.size() >= 2)
      chk("t5_dv_spacing", 32'(dv_t[dv_t.size()-1] - dv_t[dv_t.size()-2]),
          32'(stop_idx(8, 1'b0) * PRESCALE_32 + PRESCALE_32 + 1));

    // 6: reset in the middle of DATA bit 4, then a clean 0x5A frame.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, PRESCALE_8, 4 * PRESCALE_8 + 4);
    chk("t6_deser_before_rst", 32'(bus.deser_en), 32'd1);
    chk("t6_bit_cnt_before",   32'(bus.bit_cnt),  32'd4);
    #1 RST = 1'b0;
    #1;
    chk("t6_rst_edge_cnt",    32'(bus.edge_cnt),    32'd0);
    chk("t6_rst_bit_cnt",     32'(bus.bit_cnt),     32'd0);
    chk("t6_rst_dat_samp_en", 32'(bus.dat_samp_en), 32'd0);
    chk("t6_rst_deser_en",    32'(bus.deser_en),    32'd0);
    chk("t6_rst_data_valid",  32'(bus.data_valid),  32'd0);
    chk("t6_rst_par_err",     32'(bus.par_err),     32'd0);
    chk("t6_rst_stp_err",     32'(bus.stp_err),     32'd0);
    bus.RX_IN       = 1'b1;
    bus.sampled_bit = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    idle(4);
    dv0 = dv_count;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, PRESCALE_8, 1000);
    idle(PRESCALE_8 + 4);
    chk("t6_dv_pulses",   32'(dv_count - dv0), 32'd1);
    chk("t6_queue_empty", 32'(exp_q.size()),   32'd0);
    chk("t6_stp_err",     32'(bus.stp_err),    32'd0);

`ifdef UART_RX_ERR_CNT_EN
    // 7: bad-frame counter saturates at 255 and clears on request.
    chk("t7_err_cnt_start", 32'(bus.err_cnt), 32'd0);
    for (int n = 0; n < 300; n++) begin
      send_frame(8'h00, 1'b0, 1'b0, 1'b0, PRESCALE_8, 1000);
      idle(2);
      if (n == 2) begin
        idle(2);
        chk("t7_err_cnt_3", 32'(bus.err_cnt), 32'd3);
      end
    end
    idle(PRESCALE_8);
    chk("t7_err_cnt_sat", 32'(bus.err_cnt), 32'd255);
    @(negedge CLK);
    bus.err_cnt_clr = 1'b1;
    @(negedge CLK);
    bus.err_cnt_clr = 1'b0;
    #1;
    chk("t7_err_cnt_clr", 32'(bus.err_cnt), 32'd0);
`endif

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
